calc_display: RTL and testbench
===============================

Name: calc_display

Overview:
- Downstream consumer of the calculator core's digit stream (status/data/pos).
- Captures one BCD nibble per cycle into a shadow buffer while the core is busy. Commits the whole frame atomically when the core returns to ready.
- Time-multiplexes the committed 8 digits onto a common-anode 7-segment bank.
- Shows a fixed "Erro" pattern when the core reports error.

Parameters:
- N_DIG, 8, number of display digits (pos range 0..N_DIG-1).
- REFRESH_DIV, 100000, clock cycles each digit stays lit; must be >= 2.
- BLANK_LZ, 1, 1 = blank leading zeros (digit 0 never blanked).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- status  in  2  core status: 00 erro, 01 ocupado, 10 pronto, 11 reserved.
- data  in  4  BCD digit from core, valid while status==01.
- pos  in  4  digit index of data (0 = least significant).
- an  out  N_DIG  anode enables, active-low, one-hot-low while running.
- seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1 (off).
- frame_valid  out  1  pulses high for one cycle on each frame commit.

Behaviour:
- Reset (reset==0, async):
  - shadow[] = 0, disp[] = 0, prev_status = 01, err_mode = 0.
  - presc = 0, scan = 0.
  - an = all 1s, seg = 8'hFF, frame_valid = 0.
- Capture:
  - Each rising edge with status==01 and pos<N_DIG: shadow[pos] <= data.
  - pos>=N_DIG is ignored.
  - data values 10..15 are stored as-is and render blank.
- Commit:
  - Condition: prev_status==01 and status==10 (detected on the registered prev_status).
  - Action: disp[] <= shadow[], frame_valid <= 1 for exactly that cycle.
  - A capture in the same cycle is not possible (status is 10), so there is no conflict.
  - prev_status <= status every cycle.
- Error:
  - status==00 on any edge sets err_mode <= 1. It is sticky; only reset clears it.
  - Capture and commit remain active but do not affect the outputs while err_mode==1.
- Reserved status 11: no capture, no commit, not error.
- Scan:
  - presc counts 0..REFRESH_DIV-1. At terminal, presc <= 0 and scan <= (scan+1) mod N_DIG.
  - an and seg are registered: one cycle of latency from scan/disp to pins.
  - First cycle after reset release: an = ~(1<<0).
- Segment source, in priority order:
  1. err_mode: digit3='E' (8'h86), digit2='r' (8'hAF), digit1='r' (8'hAF), digit0='o' (8'hA3), other digits blank (8'hFF).
  2. BLANK_LZ==1, scan!=0, and disp[j]==0 for all j>=scan: blank.
  3. Otherwise: decode disp[scan].
- Decode table (active-low, dp=1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - 10..15 = FF.
- Commit coincident with a scan tick: the new disp is used from the next registered output onward, with no partial mixing.
- Reset mid-frame: the shadow contents are lost and the display returns to "0" (digit 0 lit, others blanked).

Decomposition:
- Shared package calc_pkg:
  - Status constants ST_ERRO=2'b00, ST_OCUPADO=2'b01, ST_PRONTO=2'b10.
  - N_DIG default.
  - Segment constants SEG_BLANK, SEG_E, SEG_R, SEG_O.
- One combinational sub-module, seg7_decode: 4-bit BCD in, 8-bit active-low pattern out. Instantiated once, after the digit mux.

Test Plan (REFRESH_DIV=4, BLANK_LZ=1):
1. Reset, then hold status=10 -> an cycles FE,FD,FB,...,7F, changing every 4 clocks. seg=C0 only while an=FE, otherwise FF.
2. status=01 with pos 0..7 and data 7,2,0,0,0,0,0,0, then status=10 -> frame_valid pulses once. Display digit0=F8, digit1=A4, digits 2..7 blank.
3. Frame 1 = "123" committed. During a second frame, mid-stream data 9 is written at pos 0 while status stays 01 -> display still shows "123" until the 01->10 edge, then updates.
4. status=00 for one cycle, then status=10 -> err_mode stays set. Digits 3..0 show 86,AF,AF,A3 and digits 7..4 stay FF until reset. A later commit does not change the outputs.
5. Write pos=9 data=5 and data=12 at pos 0, then commit -> pos 9 is ignored and digit0 shows FF. An all-zero frame shows digit0=C0.
6. Assert reset (0) asynchronously mid-capture, between clock edges -> an/seg go FF immediately and frame_valid=0. After release, the display shows "0" regardless of the pre-reset shadow.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : calc_pkg
//  Brief    : Shared status codes and segment patterns for the calculator display.
//  Revision : 1.0
// ============================================================================
package calc_pkg;

    localparam logic [1:0] ST_ERRO    = 2'b00;
    localparam logic [1:0] ST_OCUPADO = 2'b01;
    localparam logic [1:0] ST_PRONTO  = 2'b10;

    localparam int N_DIG_DEFAULT = 8;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_R     = 8'hAF;
    localparam logic [7:0] SEG_O     = 8'hA3;

    // "Erro" occupies digits 3..0; every other position stays dark.
    function automatic logic [7:0] err_pattern(input int idx);
        case (idx)
            3:       err_pattern = SEG_E;
            2:       err_pattern = SEG_R;
            1:       err_pattern = SEG_R;
            0:       err_pattern = SEG_O;
            default: err_pattern = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Brief    : BCD to active-low 7-segment pattern {dp,g,f,e,d,c,b,a}.
//  Revision : 1.0
// ============================================================================
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [7:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = 8'hC0;
            4'd1:    o_seg = 8'hF9;
            4'd2:    o_seg = 8'hA4;
            4'd3:    o_seg = 8'hB0;
            4'd4:    o_seg = 8'h99;
            4'd5:    o_seg = 8'h92;
            4'd6:    o_seg = 8'h82;
            4'd7:    o_seg = 8'hF8;
            4'd8:    o_seg = 8'h80;
            4'd9:    o_seg = 8'h90;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc_display.sv
`default_nettype none
// ============================================================================
//  Module   : calc_display
//  Brief    : Frame-buffered, multiplexed 7-segment driver for the calculator core.
//  Revision : 1.0
// ============================================================================
module calc_display
    import calc_pkg::*;
#(
    parameter int N_DIG       = N_DIG_DEFAULT,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       status,
    input  logic [3:0]       data,
    input  logic [3:0]       pos,
    output logic [N_DIG-1:0] an,
    output logic [7:0]       seg,
    output logic             frame_valid
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [PW-1:0] C_PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] C_SCAN_LAST  = SW'(N_DIG - 1);

    logic [3:0]       r_shadow [N_DIG];
    logic [3:0]       r_disp   [N_DIG];
    logic [1:0]       r_prev_status;
    logic             r_err_mode;
    logic [PW-1:0]    r_presc;
    logic [SW-1:0]    r_scan;
    logic [N_DIG-1:0] r_an;
    logic [7:0]       r_seg;
    logic             r_frame_valid;

    logic             w_capture;
    logic             w_commit;
    logic             w_tick;
    logic             w_upper_nz;
    logic             w_blank_lz;
    logic [3:0]       w_digit;
    logic [7:0]       w_dec_seg;
    logic [7:0]       w_seg_next;
    logic [N_DIG-1:0] w_an_next;

    always_comb begin
        w_capture = (status == ST_OCUPADO) && (int'(pos) < N_DIG);
        w_commit  = (r_prev_status == ST_OCUPADO) && (status == ST_PRONTO);
        w_tick    = (r_presc == C_PRESC_LAST);
    end

    // A digit is dark when it and everything more significant is zero.
    always_comb begin
        w_upper_nz = 1'b0;
        w_digit    = 4'd0;
        for (int j = 0; j < N_DIG; j++) begin
            if ((j >= int'(r_scan)) && (r_disp[j] != 4'd0)) begin
                w_upper_nz = 1'b1;
            end
            if (r_scan == SW'(j)) begin
                w_digit = r_disp[j];
            end
        end
        w_blank_lz = (BLANK_LZ != 0) && (r_scan != '0) && !w_upper_nz;
    end

    seg7_decode u_seg7_decode (
        .i_bcd (w_digit),
        .o_seg (w_dec_seg)
    );

    always_comb begin
        if (r_err_mode) begin
            w_seg_next = err_pattern(int'(r_scan));
        end else if (w_blank_lz) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = w_dec_seg;
        end
        w_an_next = ~(N_DIG'(1) << r_scan);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_DIG; i++) begin
                r_shadow[i] <= 4'd0;
                r_disp[i]   <= 4'd0;
            end
            r_prev_status <= ST_OCUPADO;
            r_err_mode    <= 1'b0;
            r_presc       <= '0;
            r_scan        <= '0;
            r_an          <= '1;
            r_seg         <= SEG_BLANK;
            r_frame_valid <= 1'b0;
        end else begin
            for (int i = 0; i < N_DIG; i++) begin
                if (w_capture && (pos == 4'(i))) begin
                    r_shadow[i] <= data;
                end
            end
            if (w_commit) begin
                r_disp <= r_shadow;
            end
            r_frame_valid <= w_commit;
            r_prev_status <= status;
            if (status == ST_ERRO) begin
                r_err_mode <= 1'b1;
            end
            if (w_tick) begin
                r_presc <= '0;
                r_scan  <= (r_scan == C_SCAN_LAST) ? '0 : r_scan + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_display
//  Brief    : Self-checking bench for calc_display against a frame-level model.
//  Revision : 1.0
// ============================================================================
module tb_calc_display;

    localparam int ND  = 8;
    localparam int DIV = 4;

    logic          clock;
    logic          reset;
    logic [1:0]    status;
    logic [3:0]    data;
    logic [3:0]    pos;
    logic [ND-1:0] an;
    logic [7:0]    seg;
    logic          frame_valid;

    calc_display #(
        .N_DIG       (ND),
        .REFRESH_DIV (DIV),
        .BLANK_LZ    (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .status      (status),
        .data        (data),
        .pos         (pos),
        .an          (an),
        .seg         (seg),
        .frame_valid (frame_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Frame-level model: the digit number shown, plus elapsed cycles since reset.
    int         m_shadow [ND];
    int         m_disp   [ND];
    bit         m_err;
    logic [1:0] m_prev;
    int         m_cyc;
    logic [7:0] e_an, e_seg;
    logic       e_fv;

    function automatic logic [7:0] glyph(input int d);
        logic [7:0] lut [10];
        lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return (d < 10) ? lut[d] : 8'hFF;
    endfunction

    function automatic logic [7:0] model_seg(input int s);
        bit lit;
        if (m_err) begin
            case (s)
                3: return 8'h86;
                2: return 8'hAF;
                1: return 8'hAF;
                0: return 8'hA3;
                default: return 8'hFF;
            endcase
        end
        lit = (s == 0);
        for (int j = s; j < ND; j++) if (m_disp[j] != 0) lit = 1;
        return lit ? glyph(m_disp[s]) : 8'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_shadow[i] = 0;
            m_disp[i]   = 0;
        end
        m_err  = 0;
        m_prev = 2'b01;
        m_cyc  = 0;
    endtask

    task automatic model_edge();
        int s;
        s     = (m_cyc / DIV) % ND;
        e_an  = ~(8'd1 << s);
        e_seg = model_seg(s);
        e_fv  = (m_prev == 2'b01) && (status == 2'b10);
        if (status == 2'b01 && int'(pos) < ND) m_shadow[pos] = int'(data);
        if (e_fv) m_disp = m_shadow;
        if (status == 2'b00) m_err = 1;
        m_prev = status;
        m_cyc++;
    endtask

    task automatic check(input string tag);
        total++;
        assert (an === e_an) else begin
            bad++;
            $error("FAIL %s an: got %h want %h", tag, an, e_an);
        end
        total++;
        assert (seg === e_seg) else begin
            bad++;
            $error("FAIL %s seg: got %h want %h", tag, seg, e_seg);
        end
        total++;
        assert (frame_valid === e_fv) else begin
            bad++;
            $error("FAIL %s frame_valid: got %b want %b", tag, frame_valid, e_fv);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        if (reset) begin
            model_edge();
        end else begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
            e_fv  = 1'b0;
        end
        #1;
        check(tag);
    endtask

    task automatic drive(input logic [1:0] s, input int d, input int p);
        status = s;
        data   = 4'(d);
        pos    = 4'(p);
    endtask

    task automatic write_frame(input int d0, input int d1, input int d2, input int d3,
                               input int d4, input int d5, input int d6, input int d7,
                               input string tag);
        int v [ND];
        v = '{d0, d1, d2, d3, d4, d5, d6, d7};
        for (int i = 0; i < ND; i++) begin
            drive(2'b01, v[i], i);
            tick(tag);
        end
    endtask

    task automatic hold(input logic [1:0] s, input int n, input string tag);
        drive(s, 0, 0);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset = 1'b0;
        drive(2'b10, 0, 0);
        model_reset();
        tick("reset");
        tick("reset");
        reset = 1'b1;

        // Idle after reset: single "0" scanning across the bank.
        hold(2'b10, 2 * ND * DIV, "idle_scan");

        // "27" frame.
        write_frame(7, 2, 0, 0, 0, 0, 0, 0, "cap72");
        hold(2'b10, ND * DIV + 3, "show72");

        // "123" then a mid-stream overwrite that must stay hidden until commit.
        write_frame(3, 2, 1, 0, 0, 0, 0, 0, "cap123");
        hold(2'b10, ND * DIV, "show123");
        drive(2'b01, 9, 0);
        for (int i = 0; i < 12; i++) tick("midframe");
        hold(2'b10, ND * DIV, "show129");

        // Out-of-range pos and non-BCD data, then an all-zero frame.
        drive(2'b01, 5, 9);
        tick("pos9");
        drive(2'b01, 12, 0);
        tick("data12");
        hold(2'b10, ND * DIV, "show_blank0");
        write_frame(0, 0, 0, 0, 0, 0, 0, 0, "cap0");
        hold(2'b10, ND * DIV, "show0");

        // Randomized traffic without error status.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)      drive(2'b01, $urandom_range(0, 15), $urandom_range(0, 9));
            else if (r < 9) drive(2'b10, 0, 0);
            else            drive(2'b11, $urandom_range(0, 15), $urandom_range(0, 9));
            tick("random");
        end

        // Asynchronous reset in the middle of a capture.
        write_frame(4, 5, 6, 0, 0, 0, 0, 0, "cap456");
        hold(2'b10, 6, "show456");
        drive(2'b01, 8, 0);
        tick("precap");
        drive(2'b01, 8, 1);
        #3;
        reset = 1'b0;
        #1;
        e_an  = 8'hFF;
        e_seg = 8'hFF;
        e_fv  = 1'b0;
        check("async_reset");
        model_reset();
        tick("in_reset");
        tick("in_reset");
        reset = 1'b1;
        hold(2'b10, ND * DIV, "after_reset");

        // Sticky error mode with traffic continuing underneath.
        write_frame(1, 2, 3, 4, 5, 6, 7, 8, "cap_pre_err");
        hold(2'b10, 3, "pre_err");
        hold(2'b00, 1, "err_pulse");
        hold(2'b10, ND * DIV, "err_show");
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      drive(2'b01, $urandom_range(0, 15), $urandom_range(0, 9));
            else if (r < 9) drive(2'b10, 0, 0);
            else            drive(2'(r & 3), 0, 0);
            tick("err_random");
        end

        // Reset clears error mode.
        reset = 1'b0;
        #1;
        model_reset();
        tick("err_reset");
        reset = 1'b1;
        hold(2'b10, ND * DIV, "post_err");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
